// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_co   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Results are written only on the final RUN edge so sum/c_out never show partial bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
            r_res   <= '0;
          end
        end
        RUN: begin
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= {w_s, r_res[WIDTH-1:1]};
            r_cout <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last bit r_carry is the carry into the MSB slice and w_co the carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= r_carry ^ w_co;
  end

  assign ovf = r_ovf;
`endif

  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder (WIDTH=8) against an arithmetic reference.
// Covers the optional ovf output when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int checkCount = 0;
  int passCount  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Signed overflow: the true signed sum does not fit in WIDTH bits.
  function automatic logic refOvf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    int sx;
    int sy;
    int t;
    sx = int'($signed(x));
    sy = int'($signed(y));
    t  = sx + sy + (c ? 1 : 0);
    return (t > 127) || (t < -128);
  endfunction

  // Drives one add and reports what was observed; comparisons are made by the callers.
  task automatic runAdd(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                        output logic [WIDTH-1:0] s, output logic co, output logic ov,
                        output int edges, output int busyCycles, output logic doneAfter,
                        output logic sumStable, output logic ok);
    logic [WIDTH-1:0] sum0;
    logic             co0;
    @(negedge clk);
    a = av; b = bv; c_in = cv; start = 1'b1;
    sum0 = sum; co0 = c_out;
    edges = 0; busyCycles = 0; ok = 1'b0; sumStable = 1'b1;
    s = '0; co = 1'b0; ov = 1'b0; doneAfter = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (busy) begin
        busyCycles++;
        if (sum !== sum0 || c_out !== co0) sumStable = 1'b0;
      end
      if (done) begin
        ok = 1'b1;
        s  = sum;
        co = c_out;
`ifdef SERIAL_ADDER_OVF_EN
        ov = ovf;
`endif
        break;
      end
    end
    if (ok) begin
      @(negedge clk);
      doneAfter = done;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({busy, done, sum, c_out} !== '0) $display("[TB] FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy, done, sum, c_out);
    else passCount++;
`ifdef SERIAL_ADDER_OVF_EN
    checkCount++;
    if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b want 0", ovf);
    else passCount++;
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] av [3] = '{8'h3C, 8'hFF, 8'hFF};
    logic [WIDTH-1:0] bv [3] = '{8'h05, 8'h01, 8'hFF};
    logic             cv [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] s;
    logic             co, ov, doneAfter, sumStable, ok;
    logic [WIDTH:0]   expv;
    int               edges, busyCycles;
    for (int i = 0; i < 3; i++) begin
      runAdd(av[i], bv[i], cv[i], s, co, ov, edges, busyCycles, doneAfter, sumStable, ok);
      expv = (WIDTH+1)'(av[i]) + (WIDTH+1)'(bv[i]) + (WIDTH+1)'(cv[i]);
      checkCount++;
      if (!ok) $display("[TB] FAIL directed_timeout[%0d]: done never seen, want done", i);
      else passCount++;
      checkCount++;
      if ({co, s} !== expv) $display("[TB] FAIL directed_sum[%0d]: got c_out=%b sum=%h want c_out=%b sum=%h", i, co, s, expv[WIDTH], expv[WIDTH-1:0]);
      else passCount++;
      checkCount++;
      if (busyCycles != WIDTH) $display("[TB] FAIL directed_busy[%0d]: got %0d busy cycles want %0d", i, busyCycles, WIDTH);
      else passCount++;
      checkCount++;
      if (doneAfter !== 1'b0) $display("[TB] FAIL directed_done_width[%0d]: done still %b one cycle later, want 0", i, doneAfter);
      else passCount++;
      checkCount++;
      if (!sumStable) $display("[TB] FAIL directed_no_partial[%0d]: sum/c_out changed during RUN, want held", i);
      else passCount++;
    end
  endtask

  task automatic test_start_ignored;
    int               totalDone;
    logic [WIDTH-1:0] firstSum;
    logic             firstCo;
    logic             seen;
    totalDone = 0; seen = 1'b0; firstSum = '0; firstCo = 1'b0;
    @(negedge clk);
    a = 8'h3C; b = 8'h05; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = '0; b = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        totalDone++; seen = 1'b1; firstSum = sum; firstCo = c_out;
      end
    end
    checkCount++;
    if ({firstCo, firstSum} !== 9'h041) $display("[TB] FAIL held_start_sum: got c_out=%b sum=%h want c_out=0 sum=41", firstCo, firstSum);
    else passCount++;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL held_start_idle: got busy=%b done=%b after DONE want 0 0", busy, done);
    else passCount++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkCount++;
    if (busy !== 1'b1) $display("[TB] FAIL held_start_reaccept: got busy=%b want 1", busy);
    else passCount++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) totalDone++;
    end
    checkCount++;
    if (totalDone != 2) $display("[TB] FAIL held_start_pulses: got %0d done pulses want 2", totalDone);
    else passCount++;
    checkCount++;
    if ({c_out, sum} !== 9'h000) $display("[TB] FAIL held_start_second_sum: got c_out=%b sum=%h want 0 00", c_out, sum);
    else passCount++;
  endtask

  task automatic test_reset_midrun;
    logic [WIDTH-1:0] s;
    logic             co, ov, doneAfter, sumStable, ok;
    int               edges, busyCycles, doneCount, busyCount;
    runAdd(8'h3C, 8'h05, 1'b0, s, co, ov, edges, busyCycles, doneAfter, sumStable, ok);
    @(negedge clk);
    a = 8'h55; b = 8'h22; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if ({busy, done, sum, c_out} !== '0) $display("[TB] FAIL midrun_reset: got busy=%b done=%b sum=%h c_out=%b want all 0", busy, done, sum, c_out);
    else passCount++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0; busyCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) doneCount++;
      if (busy) busyCount++;
    end
    checkCount++;
    if (doneCount != 0 || busyCount != 0) $display("[TB] FAIL midrun_no_done: got done=%0d busy=%0d cycles want 0 0", doneCount, busyCount);
    else passCount++;
    runAdd(8'h10, 8'h20, 1'b0, s, co, ov, edges, busyCycles, doneAfter, sumStable, ok);
    checkCount++;
    if (!ok || {co, s} !== 9'h030) $display("[TB] FAIL midrun_after: got ok=%b c_out=%b sum=%h want ok=1 c_out=0 sum=30", ok, co, s);
    else passCount++;
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    logic [WIDTH-1:0] av [3] = '{8'h7F, 8'h80, 8'h40};
    logic [WIDTH-1:0] bv [3] = '{8'h01, 8'h80, 8'h10};
    logic [WIDTH-1:0] s;
    logic             co, ov, doneAfter, sumStable, ok, expOv;
    logic [WIDTH:0]   expv;
    int               edges, busyCycles;
    for (int i = 0; i < 3; i++) begin
      runAdd(av[i], bv[i], 1'b0, s, co, ov, edges, busyCycles, doneAfter, sumStable, ok);
      expv  = (WIDTH+1)'(av[i]) + (WIDTH+1)'(bv[i]);
      expOv = refOvf(av[i], bv[i], 1'b0);
      checkCount++;
      if (!ok || {co, s} !== expv || ov !== expOv) $display("[TB] FAIL ovf[%0d]: got ok=%b c_out=%b sum=%h ovf=%b want c_out=%b sum=%h ovf=%b", i, ok, co, s, ov, expv[WIDTH], expv[WIDTH-1:0], expOv);
      else passCount++;
    end
  endtask
`endif

  task automatic test_random;
    logic [WIDTH-1:0] av, bv, s;
    logic             cv, co, ov, doneAfter, sumStable, ok;
    logic [WIDTH:0]   expv;
    int               edges, busyCycles;
    for (int n = 0; n < 200; n++) begin
      av = WIDTH'($urandom_range(0, 255));
      bv = WIDTH'($urandom_range(0, 255));
      cv = 1'($urandom_range(0, 1));
      runAdd(av, bv, cv, s, co, ov, edges, busyCycles, doneAfter, sumStable, ok);
      expv = (WIDTH+1)'(av) + (WIDTH+1)'(bv) + (WIDTH+1)'(cv);
      checkCount++;
      if (!ok || {co, s} !== expv) $display("[TB] FAIL random_sum[%0d]: %h+%h+%b got ok=%b c_out=%b sum=%h want %b %h", n, av, bv, cv, ok, co, s, expv[WIDTH], expv[WIDTH-1:0]);
      else passCount++;
      checkCount++;
      if (edges != WIDTH + 1) $display("[TB] FAIL random_latency[%0d]: got done after %0d edges want %0d", n, edges, WIDTH + 1);
      else passCount++;
      checkCount++;
      if (doneAfter !== 1'b0 || !sumStable) $display("[TB] FAIL random_pulse[%0d]: got doneAfter=%b sumStable=%b want 0 1", n, doneAfter, sumStable);
      else passCount++;
`ifdef SERIAL_ADDER_OVF_EN
      checkCount++;
      if (ov !== refOvf(av, bv, cv)) $display("[TB] FAIL random_ovf[%0d]: got %b want %b", n, ov, refOvf(av, bv, cv));
      else passCount++;
`endif
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_ignored;
    test_reset_midrun;
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf;
`endif
    test_random;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
